// File: rtl/tcni_sched_pkg.sv
// Shared types and constants for the TCNI scheduling queue.
// Holds the memory word/offset types, TCNI status codes, register indices,
// the FSM state enum and the queued entry struct.
package tcni_sched_pkg;

  typedef logic [31:0] memword;
  typedef logic [15:0] memoffset;

  // TCNI status codes; 5..7 are folded onto IDLE by status_norm().
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_BUSY  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // MMIO word indices (byte address bits [4:2]).
  localparam logic [2:0] REG_TIME = 3'd0;
  localparam logic [2:0] REG_LOC  = 3'd1;
  localparam logic [2:0] REG_STAT = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_IRQ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } sched_state_t;

  typedef struct packed {
    memword   inj_time;
    memoffset loc;
  } entry_t;

  function automatic logic [2:0] status_norm(input logic [2:0] s);
    return (s > ST_ERROR) ? ST_IDLE : s;
  endfunction

endpackage

// File: rtl/tcni_sched_fifo.sv
// Synchronous FIFO of scheduling entries with flush.
// Ports: push/pop/flush strobes, din entry in; head entry, count, full, empty out.
// Flush wins over push and pop; a push while full is accepted only alongside a pop.
module tcni_sched_fifo
  import tcni_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; head is only consumed when count is non-zero.
  always_ff @(posedge clock_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tcni_sched_queue.sv
// TCNI scheduling queue: MMIO-fed FIFO of (time, location) entries presented to the TCNI.
// Ports: clock_in/reset_in; mmio_* register window (ack one cycle after strobe);
// injection_time_out/data_location_out to TCNI; tcni_status_in from TCNI; irq_out.
// Optional feature macro: TCNI_SCHED_IRQ_EN adds the IRQ register and drives irq_out.
module tcni_sched_queue
  import tcni_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clock_in,
  input  logic     reset_in,
  input  memword   mmio_addr_in,
  input  memword   mmio_data_in,
  input  logic     mmio_wr_in,
  input  logic     mmio_rd_in,
  output memword   mmio_data_out,
  output logic     mmio_ack_out,
  output memword   injection_time_out,
  output memoffset data_location_out,
  input  logic [2:0] tcni_status_in,
  output logic     irq_out
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int OFFW = $bits(memoffset);

  sched_state_t state_q, state_d;
  memword       inj_time_q, inj_time_d;
  memoffset     loc_q, loc_d;
  logic [2:0]   prev_status_q;
  logic [2:0]   status_n;
  logic         enable_q;
  memword       staged_q;
  logic         ovf_q;
  logic         err_q;
  memword       rdata_q;
  logic         ack_q;
  memword       rd_val;

  logic [2:0]   reg_idx;
  logic         wr_time, wr_loc, wr_ctrl;
  logic         flush, clr;
  logic         done_edge;
  logic         pop;
  logic         enter_halt;
  logic         addr_unused;

  entry_t         push_entry;
  entry_t         head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

`ifdef TCNI_SCHED_IRQ_EN
  logic [1:0] irq_q;
  logic       irq_r;
  logic       wr_irq;
  logic       drained_set;
`endif

  assign reg_idx     = mmio_addr_in[4:2];
  assign addr_unused = ^{mmio_addr_in[31:5], mmio_addr_in[1:0]};
  assign wr_time     = mmio_wr_in && (reg_idx == REG_TIME);
  assign wr_loc      = mmio_wr_in && (reg_idx == REG_LOC);
  assign wr_ctrl     = mmio_wr_in && (reg_idx == REG_CTRL);
  assign flush       = wr_ctrl && mmio_data_in[1];
  assign clr         = wr_ctrl && mmio_data_in[2];

  // A held DONE must retire only one entry, so qualify on the rising edge.
  assign status_n  = status_norm(tcni_status_in);
  assign done_edge = (status_n == ST_DONE) && (prev_status_q != ST_DONE);

  assign push_entry = '{inj_time: staged_q, loc: mmio_data_in[OFFW-1:0]};

  tcni_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push     (wr_loc),
    .pop      (pop),
    .flush    (flush),
    .din      (push_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // FSM state register together with the outputs it drives.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      inj_time_q <= '0;
      loc_q      <= '0;
    end else begin
      state_q    <= state_d;
      inj_time_q <= inj_time_d;
      loc_q      <= loc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inj_time_d = inj_time_q;
    loc_d      = loc_q;
    pop        = 1'b0;
    enter_halt = 1'b0;
    if (flush) begin
      state_d    = S_IDLE;
      inj_time_d = '0;
      loc_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_q && (count != '0)) state_d = S_LOAD;
        end
        S_LOAD: begin
          inj_time_d = head.inj_time;
          loc_d      = head.loc;
          state_d    = S_WAIT;
        end
        S_WAIT, S_RUN: begin
          if (done_edge) begin
            pop        = 1'b1;
            inj_time_d = '0;
            loc_d      = '0;
            state_d    = S_IDLE;
          end else if (status_n == ST_ERROR) begin
            // Head stays queued so software can retry after clearing.
            enter_halt = 1'b1;
            inj_time_d = '0;
            loc_d      = '0;
            state_d    = S_HALT;
          end else if ((state_q == S_WAIT) && (status_n == ST_BUSY)) begin
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          if (clr) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Register file, sticky flags and MMIO response.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      prev_status_q <= ST_IDLE;
      enable_q      <= 1'b0;
      staged_q      <= '0;
      ovf_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
    end else begin
      prev_status_q <= status_n;
      if (wr_time) staged_q <= mmio_data_in;
      // Halt entry wins over a same-cycle CTRL write.
      if (enter_halt)   enable_q <= 1'b0;
      else if (wr_ctrl) enable_q <= mmio_data_in[0];
      if (wr_loc && full && !pop && !flush) ovf_q <= 1'b1;
      else if (clr)                         ovf_q <= 1'b0;
      if (enter_halt) err_q <= 1'b1;
      else if (clr)   err_q <= 1'b0;
      ack_q   <= mmio_wr_in || mmio_rd_in;
      rdata_q <= mmio_rd_in ? rd_val : '0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_TIME: rd_val = staged_q;
      REG_STAT: rd_val = {14'd0, state_q, tcni_status_in, err_q, ovf_q,
                          full, empty, 8'(count)};
      REG_CTRL: rd_val = {31'd0, enable_q};
`ifdef TCNI_SCHED_IRQ_EN
      REG_IRQ:  rd_val = {30'd0, irq_q};
`endif
      default:  rd_val = '0;
    endcase
  end

`ifdef TCNI_SCHED_IRQ_EN
  assign wr_irq = mmio_wr_in && (reg_idx == REG_IRQ);
  // A pop with a simultaneous push keeps count unchanged, so it does not drain.
  assign drained_set = pop && (count == CW'(1)) && !wr_loc;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      irq_q <= 2'b00;
      irq_r <= 1'b0;
    end else begin
      irq_q <= (irq_q & ~(wr_irq ? mmio_data_in[1:0] : 2'b00))
             | {enter_halt, drained_set};
      irq_r <= |irq_q;
    end
  end

  assign irq_out = irq_r;
`else
  assign irq_out = 1'b0;
`endif

  assign injection_time_out = inj_time_q;
  assign data_location_out  = loc_q;
  assign mmio_data_out      = rdata_q;
  assign mmio_ack_out       = ack_q;

endmodule
